// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue slice.
// FQ_DEPTH is the default buffer depth.
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [1:0]  bp;
  } fetch_data_t;

endpackage

// File: rtl/squash_if.sv
// Pipeline squash request.
// Only valid is carried.
interface squash_if;
  logic valid;
  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/fq_storage.sv
// Register array for the fetch queue.
// One write port, one async read port.
module fq_storage
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  fetch_data_t       wdata,
  input  logic [AW-1:0]     raddr,
  output fetch_data_t       rdata
);

  fetch_data_t r_mem [DEPTH];

  // write the addressed slot; contents are never reset
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Elastic fetch-to-decode instruction buffer.
// FETCH_QUEUE_BYPASS_EN: forward in_i to out_o when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  fetch_data_t      in_i,
  input  logic             in_i_valid,
  output logic             in_i_ready,
  output fetch_data_t      out_o,
  output logic             out_o_valid,
  input  logic             out_o_ready,
  squash_if.slave          squash_io,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic        w_act;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_we;
  logic        w_rd;
  logic        w_byp;
  fetch_data_t w_rdata;

  assign w_act   = rstn & ~squash_io.valid;
  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_act & w_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign in_i_ready  = w_act & ~w_full;
  assign out_o_valid = w_byp ? in_i_valid
                             : (w_act & ~w_empty);
  assign out_o       = w_byp ? in_i : w_rdata;
  assign count_o     = rstn ? r_count : '0;

  assign w_push = in_i_valid & in_i_ready;
  assign w_pop  = out_o_valid & out_o_ready;
  // a bypassed entry consumed this cycle never lands
  assign w_we   = w_push & ~(w_byp & w_pop);
  assign w_rd   = w_pop & ~w_byp;

  fq_storage #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_tail),
    .wdata (in_i),
    .raddr (r_head),
    .rdata (w_rdata)
  );

  // pointer and occupancy tracking; reset and squash empty the queue
  always_ff @(posedge clk) begin
    if (!rstn || squash_io.valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_we) r_tail <= r_tail + 1'b1;
      if (w_rd) r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(w_we)
                         - CNT_W'(w_rd);
    end
  end

  // structural invariants
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (r_count <= FULL);
      assert (!(w_push && w_full));
      assert (!(w_rd && w_empty));
      assert (!out_o_valid || !$isunknown(out_o.pc));
    end
  end

endmodule
